// File: rtl/arb_pkg.sv
// Shared encodings for the two-port memory arbiter.
// Holds the memory command codes, the arbiter FSM states and the requester count.
package arb_pkg;

    localparam int NUM_PORTS = 2;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_ACK   = 2'b11
    } state_e;

    function automatic logic rw_legal(input logic [1:0] rw);
        return (rw == RW_READ) || (rw == RW_WRITE);
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: combinational, zero latency.
// With both requests high the pointer's requester wins; no state held here.
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic                 i_req0,
    input  logic                 i_req1,
    input  logic                 i_ptr,
    output logic [NUM_PORTS-1:0] o_gnt
);

    assign o_gnt[0] = i_req0 & (~i_req1 | ~i_ptr);
    assign o_gnt[1] = i_req1 & (~i_req0 |  i_ptr);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter, one transaction in flight; REQ to ACK in 3 cycles minimum.
// Requesters hold REQ until their ACK pulse; memory stalls via MEMRDY, bounded by TIMEOUT.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  Arb_CLK,
    input  logic                  Arb_RST,
    input  logic                  Arb_REQ0,
    input  logic                  Arb_REQ1,
    input  logic [1:0]            Arb_RW0,
    input  logic [1:0]            Arb_RW1,
    input  logic [ADDR_WIDTH-1:0] Arb_ADDR0,
    input  logic [ADDR_WIDTH-1:0] Arb_ADDR1,
    input  logic [DATA_WIDTH-1:0] Arb_WDATA0,
    input  logic [DATA_WIDTH-1:0] Arb_WDATA1,
    output logic                  Arb_ACK0,
    output logic                  Arb_ACK1,
    output logic [DATA_WIDTH-1:0] Arb_RDATA0,
    output logic [DATA_WIDTH-1:0] Arb_RDATA1,
    output logic [1:0]            Arb_MEMRW,
    output logic [ADDR_WIDTH-1:0] Arb_MEMADDR,
    output logic [DATA_WIDTH-1:0] Arb_MEMIDR,
    input  logic [DATA_WIDTH-1:0] Arb_MEMODR,
    input  logic                  Arb_MEMRDY,
    output logic                  Arb_ERR
);

    // Counter only has to reach TIMEOUT-1: WAIT cycles are numbered 0..TIMEOUT-1.
    localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    state_e                  r_state;
    state_e                  w_next;
    logic                    r_ptr;
    logic                    r_win;
    logic [1:0]              r_rw;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [CW-1:0]           r_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata0;
    logic [DATA_WIDTH-1:0]   r_rdata1;
    logic                    r_err;

    logic [NUM_PORTS-1:0]    w_gnt;
    logic                    w_any;
    logic                    w_sel;
    logic                    w_legal;
    logic                    w_timeout;

    arb_rr_pick u_pick (
        .i_req0 (Arb_REQ0),
        .i_req1 (Arb_REQ1),
        .i_ptr  (r_ptr),
        .o_gnt  (w_gnt)
    );

    assign w_any     = |w_gnt;
    assign w_sel     = w_gnt[1];
    assign w_legal   = rw_legal(r_rw);
    assign w_timeout = !Arb_MEMRDY && (r_cnt == CNT_LAST);

    always_ff @(posedge Arb_CLK or negedge Arb_RST) begin
        if (!Arb_RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_next = ST_ISSUE;
            ST_ISSUE: w_next = w_legal ? ST_WAIT : ST_ACK;
            ST_WAIT:  if (Arb_MEMRDY || w_timeout) w_next = ST_ACK;
            ST_ACK:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Arb_CLK or negedge Arb_RST) begin
        if (!Arb_RST) begin
            r_ptr    <= 1'b0;
            r_win    <= 1'b0;
            r_rw     <= RW_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_win   <= w_sel;
                        r_ptr   <= ~w_sel;
                        r_rw    <= w_sel ? Arb_RW1    : Arb_RW0;
                        r_addr  <= w_sel ? Arb_ADDR1  : Arb_ADDR0;
                        r_wdata <= w_sel ? Arb_WDATA1 : Arb_WDATA0;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= '0;
                    if (!w_legal) r_err <= 1'b1;
                end
                ST_WAIT: begin
                    if (Arb_MEMRDY) begin
                        if (r_rw == RW_READ) begin
                            if (r_win) r_rdata1 <= Arb_MEMODR;
                            else       r_rdata0 <= Arb_MEMODR;
                        end
                    end else if (w_timeout) begin
                        // Abandoned transaction returns zero so stale data is never mistaken for a result.
                        if (r_win) r_rdata1 <= '0;
                        else       r_rdata0 <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Arb_MEMRW   = ((r_state == ST_ISSUE || r_state == ST_WAIT) && w_legal) ? r_rw : RW_IDLE;
    assign Arb_MEMADDR = r_addr;
    assign Arb_MEMIDR  = r_wdata;
    assign Arb_ACK0    = (r_state == ST_ACK) && !r_win;
    assign Arb_ACK1    = (r_state == ST_ACK) &&  r_win;
    assign Arb_RDATA0  = r_rdata0;
    assign Arb_RDATA1  = r_rdata1;
    assign Arb_ERR     = r_err;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 24, pixel word width.
REQ-002 Parameter ADDR_WIDTH, default 32, memory address width.
REQ-003 Parameter TIMEOUT, default 1023, max cycles spent waiting for Arb_MEMRDY.
REQ-004 Arb_CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 Arb_RST  in  1  reset, asynchronous, active-low.
REQ-006 Arb_REQn  in  1  transaction request from requester n (n = 0, 1).
REQ-007 Arb_RWn  in  2  requester n operation: 2'b01 read, 2'b10 write, 2'b00/2'b11 illegal.
REQ-008 Arb_ADDRn  in  ADDR_WIDTH  requester n address.
REQ-009 Arb_WDATAn  in  DATA_WIDTH  requester n write data.
REQ-010 Arb_ACKn  out  1  one-cycle completion pulse to requester n.
REQ-011 Arb_RDATAn  out  DATA_WIDTH  read data returned to requester n.
REQ-012 Arb_MEMRW  out  2  memory command: 2'b00 idle, 2'b01 read, 2'b10 write.
REQ-013 Arb_MEMADDR  out  ADDR_WIDTH  memory address.
REQ-014 Arb_MEMIDR  out  DATA_WIDTH  memory write data.
REQ-015 Arb_MEMODR  in  DATA_WIDTH  memory read data.
REQ-016 Arb_MEMRDY  in  1  memory transaction complete.
REQ-017 Arb_ERR  out  1  sticky error flag (timeout or illegal command).

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, ACK; exactly one memory transaction in flight.
REQ-019 IDLE: on an edge with any Arb_REQn high, latch winner's RW/ADDR/WDATA and go to ISSUE; else stay.
REQ-020 Arbitration round-robin: single pointer; both requesting -> pointer's requester wins; after any grant, pointer moves to the other requester.
REQ-021 ISSUE: drive latched RW/ADDR/WDATA on memory port for one cycle, go to WAIT; illegal RW -> Arb_MEMRW stays 2'b00, set Arb_ERR, go directly to ACK.
REQ-022 WAIT: hold Arb_MEMRW/ADDR/IDR stable; on edge sampling Arb_MEMRDY=1 go to ACK, capturing Arb_MEMODR into winner's Arb_RDATAn if read.
REQ-023 Timeout: WAIT cycle counter; on reaching TIMEOUT without Arb_MEMRDY, go to ACK, winner's Arb_RDATAn <= 0, set Arb_ERR.
REQ-024 ACK: Arb_MEMRW = 2'b00, winner's Arb_ACKn = 1 for exactly this cycle, next state IDLE.
REQ-025 Latency: REQ sampled at edge k -> Arb_MEMRW valid cycle k+1 -> earliest Arb_ACKn cycle k+3 (Arb_MEMRDY high in first WAIT cycle).
REQ-026 Requester holds REQ/RW/ADDR/WDATA stable until it samples Arb_ACKn=1 and drops REQ at that same edge; a REQ still high in the IDLE after ACK is a new request.
REQ-027 Arb_RDATAn registered; holds last value until that port's next read completion; writes leave it unchanged.
REQ-028 Arb_MEMRW = 2'b00 in IDLE and ACK; Arb_MEMADDR/IDR hold last latched values.
REQ-029 Arb_ERR stays set until reset; normal arbitration continues after error.
REQ-030 Arb_MEMRDY high in IDLE/ISSUE/ACK is ignored.

Reset
REQ-031 Arb_RST low: immediately state IDLE, pointer 0, counter 0, Arb_MEMRW 2'b00, all ACK/ERR 0, all data/address outputs 0.
REQ-032 Reset mid-transaction abandons it; no ACK issued; first post-reset grant follows REQ-019/020.

Structure
REQ-033 Shared package arb_pkg: RW encodings (IDLE/READ/WRITE), FSM state encoding, port-count constant 2.
REQ-034 One sub-module arb_rr_pick: inputs two requests + pointer, outputs one-hot grant; all sequencing in mem_arbiter.

Verification
REQ-035 Single read: REQ0, RW0=01, ADDR0=0x10, memory returns 0xA1B2C3 with MEMRDY 2 cycles after MEMRW=01 -> ACK0 one pulse, RDATA0=0xA1B2C3, ERR=0.
REQ-036 Contention: REQ0 and REQ1 both high same edge after reset -> port 0 served first, then port 1 with no idle cycles beyond ACK->IDLE; repeated pair alternates 0,1,0,1.
REQ-037 Write: REQ1, RW1=10, ADDR1=0x20, WDATA1=0x00FF00 -> MEMRW=10, MEMADDR=0x20, MEMIDR=0x00FF00 held until MEMRDY; ACK1 pulse; RDATA1 unchanged.
REQ-038 Timeout: TIMEOUT=8, MEMRDY never asserted -> ACK0 after 8 WAIT cycles, RDATA0=0, ERR=1 until reset; subsequent read completes normally.
REQ-039 Illegal command: RW0=11 -> MEMRW stays 00, ACK0 pulse, ERR=1.
REQ-040 Reset mid-WAIT: Arb_RST low during WAIT -> MEMRW=00 and all outputs 0 immediately, no ACK; fresh request after release served with minimum latency.
